led_pwm_bank: RTL



---
 rtl/led_pwm_bank.sv | 109 ++++++++++
 1 files changed

// File: rtl/led_pwm_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : led_pwm_bank                                                  |
// | Description : Bank of LED channels with OFF/ON/PWM/BLINK modes driven by a  |
// |               shared prescaled PWM counter and frame-based blink phase.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module led_pwm_bank #(
  parameter int NUM_LEDS     = 5,
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 4,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [3:0]          wr_addr,
  input  logic [1:0]          wr_mode,
  input  logic [PWM_BITS-1:0] wr_duty,
  output logic [NUM_LEDS-1:0] led,
  output logic                pwm_sync
);

  localparam int c_presc_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int c_blink_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(PRESCALE - 1);
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_FRAMES - 1);
  localparam logic [PWM_BITS-1:0]  c_cnt_last   = '1;
  localparam logic [1:0] c_mode_off   = 2'd0;
  localparam logic [1:0] c_mode_on    = 2'd1;
  localparam logic [1:0] c_mode_pwm   = 2'd2;
  localparam logic [1:0] c_mode_blink = 2'd3;

  logic [c_presc_w-1:0] r_presc;
  logic [PWM_BITS-1:0]  r_cnt;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 r_phase;
  logic                 r_sync;
  logic [1:0]           r_mode [NUM_LEDS];
  logic [PWM_BITS-1:0]  r_pend [NUM_LEDS];
  logic [PWM_BITS-1:0]  r_act  [NUM_LEDS];
  logic [NUM_LEDS-1:0]  r_led;

  logic                 w_step;
  logic                 w_boundary;
  logic [NUM_LEDS-1:0]  w_hit;
  logic [NUM_LEDS-1:0]  w_pwm_on;
  logic [NUM_LEDS-1:0]  w_led_next;

  assign w_step     = (r_presc == c_presc_last);
  assign w_boundary = w_step && (r_cnt == c_cnt_last);

  // Addresses beyond the bank never match any channel, so they are dropped here.
  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
      assign w_hit[gi]      = wr_en && (wr_addr == 4'(gi));
      assign w_pwm_on[gi]   = (r_cnt < r_act[gi]);
      assign w_led_next[gi] = (r_mode[gi] == c_mode_on) ||
                              ((r_mode[gi] == c_mode_pwm) && w_pwm_on[gi]) ||
                              ((r_mode[gi] == c_mode_blink) && w_pwm_on[gi] && r_phase);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_cnt       <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_sync      <= 1'b0;
      r_led       <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        r_mode[i] <= c_mode_off;
        r_pend[i] <= '0;
        r_act[i]  <= '0;
      end
    end else begin
      r_presc <= w_step ? '0 : r_presc + c_presc_w'(1);
      if (w_step) begin
        r_cnt <= r_cnt + PWM_BITS'(1);
      end
      r_sync <= w_boundary;
      if (w_boundary) begin
        if (r_blink_cnt == c_blink_last) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
        end
      end
      r_led <= w_led_next;
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (w_hit[i]) begin
          r_mode[i] <= wr_mode;
          r_pend[i] <= wr_duty;
        end
        // A write landing on the boundary cycle bypasses pending so it is not lost a frame.
        if (w_boundary) begin
          r_act[i] <= w_hit[i] ? wr_duty : r_pend[i];
        end
      end
    end
  end

  assign led      = r_led;
  assign pwm_sync = r_sync;

endmodule
`default_nettype wire
